cdc_handshake_tx: RTL and testbench

- Source-side (sending) end of a two-phase toggle request/acknowledge clock-domain-crossing handshake.
- Accepts a data word in its own clock domain and holds it stable on a multi-bit bus.
- Flips a request toggle, then waits for the destination's acknowledge toggle. That toggle is resynchronized internally through a flop chain.
- Used wherever a multi-bit control or status word must cross into another clock domain, such as register writes from the SPI clock into the DSP clock.

---
 rtl/cdc_handshake_tx.sv | 115 +++++++++++
 tb/tb_cdc_handshake_tx.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_handshake_tx.sv
// Source side of a two-phase toggle req/ack clock-domain-crossing handshake.
// Optional timeout pulse is built only when CDC_HANDSHAKE_TX_TIMEOUT_EN is defined.
module cdc_handshake_tx #(
  parameter int DATA_WIDTH     = 32,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] xfer_data,
  output logic                  req_toggle,
  input  logic                  ack_toggle,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   xfer_q, xfer_d;
  logic                    req_q, req_d;
  logic                    done_q, done_d;
  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic                    ack_s;

  // Plain shift chain: nothing may sit between the synchronizer stages.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], ack_toggle};
  assign ack_s  = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    xfer_d  = xfer_q;
    req_d   = req_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          xfer_d  = in_data;
          req_d   = ~req_q;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ack_s == req_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      xfer_q  <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      xfer_q  <= xfer_d;
      req_q   <= req_d;
      done_q  <= done_d;
      sync_q  <= sync_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign busy       = (state_q == ST_WAIT);
  assign xfer_data  = xfer_q;
  assign req_toggle = req_q;
  assign done       = done_q;

`ifdef CDC_HANDSHAKE_TX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  // Saturating count means the pulse can only fire once per transfer.
  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    if (state_q == ST_IDLE) begin
      cnt_d = '0;
    end else if (ack_s != req_q) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
      timeout_d = (cnt_q == CNT_MAX - 1'b1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed self-checking bench for cdc_handshake_tx (SYNC_STAGES=2, TIMEOUT_CYCLES=16).
// Timeout scenario is exercised when CDC_HANDSHAKE_TX_TIMEOUT_EN is defined.
module tb_cdc_handshake_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] xfer_data;
  logic        req_toggle;
  logic        ack_toggle;
  logic        busy;
  logic        done;
  logic        timeout_err;

  logic        ack_drv = 1'b0;
  logic        ack_model_en = 1'b0;
  logic [2:0]  ack_pipe;

  int checks = 0;
  int errors = 0;

  cdc_handshake_tx #(
    .DATA_WIDTH(32),
    .SYNC_STAGES(2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .xfer_data(xfer_data),
    .req_toggle(req_toggle),
    .ack_toggle(ack_toggle),
    .busy(busy),
    .done(done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Destination model: echoes req_toggle back three cycles later.
  always @(posedge clk or posedge rst) begin
    if (rst) ack_pipe <= '0;
    else     ack_pipe <= {ack_pipe[1:0], req_toggle};
  end

  assign ack_toggle = ack_model_en ? ack_pipe[2] : ack_drv;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    ack_drv = 1'b0;
    ack_model_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (xfer_data !== 32'h0 || req_toggle !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || timeout_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_async: got xfer=%h req=%b done=%b busy=%b rdy=%b to=%b expected 0 0 0 0 1 0", xfer_data, req_toggle, done, busy, in_ready, timeout_err);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release: got rdy=%b busy=%b done=%b expected 1 0 0", in_ready, busy, done);
    end
  endtask

  task automatic test_single_word();
    do_reset();
    in_data = 32'hDEADBEEF;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (xfer_data !== 32'hDEADBEEF || req_toggle !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_accept: got xfer=%h req=%b rdy=%b busy=%b expected deadbeef 1 0 1", xfer_data, req_toggle, in_ready, busy);
    end
    ack_drv = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_done_m: got %b expected 0", done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_done_m1: got done=%b busy=%b expected 0 1", done, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_done_m2: got done=%b rdy=%b busy=%b expected 1 1 0", done, in_ready, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || xfer_data !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL single_done_pulse: got done=%b xfer=%h expected 0 deadbeef", done, xfer_data);
    end
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    int flips = 0;
    int first_flip = 0;
    int second_flip = 0;
    int done_cnt = 0;
    int held_bad = 0;
    logic prev_req;
    logic [31:0] held;
    do_reset();
    ack_model_en = 1'b1;
    in_data = 32'h00000001;
    in_valid = 1'b1;
    prev_req = 1'b0;
    held = '0;
    while (done_cnt < 2 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (req_toggle !== prev_req) begin
        flips++;
        held = xfer_data;
        if (flips == 1) begin
          first_flip = cyc;
          in_data = 32'h00000002;
        end else begin
          second_flip = cyc;
          in_valid = 1'b0;
        end
        prev_req = req_toggle;
      end
      if (busy === 1'b1 && xfer_data !== held) held_bad++;
      if (done === 1'b1) done_cnt++;
    end
    in_valid = 1'b0;
    checks++;
    if (done_cnt !== 2) begin
      errors++;
      $display("[TB] FAIL b2b_done_count: got %0d expected 2", done_cnt);
    end
    checks++;
    if (flips !== 2 || req_toggle !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_req_seq: got flips=%0d req=%b expected 2 0", flips, req_toggle);
    end
    checks++;
    if (second_flip - first_flip !== 7) begin
      errors++;
      $display("[TB] FAIL b2b_period: got %0d expected 7", second_flip - first_flip);
    end
    checks++;
    if (held_bad !== 0 || xfer_data !== 32'h00000002) begin
      errors++;
      $display("[TB] FAIL b2b_hold: got changes=%0d xfer=%h expected 0 00000002", held_bad, xfer_data);
    end
    ack_model_en = 1'b0;
    ack_drv = ack_pipe[2];
  endtask

  task automatic test_wait_stimulus();
    int bad = 0;
    do_reset();
    in_data = 32'hA5A50001;
    in_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      in_data = 32'h12345678 ^ i;
      @(negedge clk);
      if (xfer_data !== 32'hA5A50001 || req_toggle !== 1'b1 || busy !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("[TB] FAIL wait_ignore: got %0d bad cycles expected 0", bad);
    end
    ack_drv = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || req_toggle !== 1'b1 || xfer_data !== 32'hA5A50001) begin
      errors++;
      $display("[TB] FAIL wait_ack_wins: got done=%b req=%b xfer=%h expected 1 1 a5a50001", done, req_toggle, xfer_data);
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wait();
    int saw_done = 0;
    do_reset();
    in_data = 32'hCAFE0042;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    ack_drv = 1'b1;
    checks++;
    if (req_toggle !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rstwait_pre: got req=%b busy=%b expected 1 1", req_toggle, busy);
    end
    #2;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (req_toggle !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || xfer_data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL rstwait_clear: got req=%b rdy=%b busy=%b xfer=%h expected 0 1 0 0", req_toggle, in_ready, busy, xfer_data);
    end
    ack_drv = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1 || in_ready !== 1'b1) saw_done++;
    end
    checks++;
    if (saw_done !== 0) begin
      errors++;
      $display("[TB] FAIL rstwait_no_done: got %0d bad cycles expected 0", saw_done);
    end
  endtask

  task automatic test_spurious_ack();
    int saw_done = 0;
    do_reset();
    ack_drv = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done === 1'b1 || in_ready !== 1'b1) saw_done++;
    end
    checks++;
    if (saw_done !== 0) begin
      errors++;
      $display("[TB] FAIL spurious_idle: got %0d bad cycles expected 0", saw_done);
    end
    in_data = 32'h0BADF00D;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || xfer_data !== 32'h0BADF00D) begin
      errors++;
      $display("[TB] FAIL spurious_immediate: got done=%b xfer=%h expected 1 0badf00d", done, xfer_data);
    end
  endtask

  task automatic test_timeout();
    int pulses = 0;
    int pulse_cyc = 0;
    int done_seen = 0;
    do_reset();
    in_data = 32'h00C0FFEE;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (timeout_err === 1'b1) begin
        pulses++;
        pulse_cyc = i;
      end
    end
`ifdef CDC_HANDSHAKE_TX_TIMEOUT_EN
    checks++;
    if (pulses !== 1 || pulse_cyc !== 16) begin
      errors++;
      $display("[TB] FAIL timeout_pulse: got pulses=%0d at cycle %0d expected 1 at 16", pulses, pulse_cyc);
    end
`else
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("[TB] FAIL timeout_tied: got %0d pulses expected 0 (cycle %0d)", pulses, pulse_cyc);
    end
`endif
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_still_wait: got busy=%b expected 1", busy);
    end
    ack_drv = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen !== 1 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_then_done: got done pulses=%0d rdy=%b expected 1 1", done_seen, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_wait_stimulus();
    test_reset_mid_wait();
    test_spurious_ack();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
